seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential shift-and-add multiplier with a start/done handshake and selectable signed or unsigned operation. It is the next generation of the lab multiplier datapath: accumulator and shift register control are folded into one block. Operand width is generic, and the product is held stable for the seven-segment display driver between operations.

## Interface
Parameters:
- WIDTH, 4: operand width in bits; legal range 2..16. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a multiply; sampled on the rising edge, honoured only in IDLE.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- signed_mode  input  1  operand interpretation, captured when start is accepted:
  - 1: two's complement.
  - 0: unsigned.
- busy  output  1  high from the acceptance edge until the return to IDLE, inclusive of the DONE state.
- done  output  1  one-cycle pulse; product is valid and newly updated.
- product  output  2*WIDTH  result register; two's complement when signed_mode was 1.

## Operation
States:
- IDLE: waits for start; start=1 moves to CALC.
- CALC: processes one multiplier bit per cycle, WIDTH cycles.
- DONE: one cycle; done=1.
- DONE always returns to IDLE.

On acceptance (IDLE with start=1):
- Capture the operand magnitudes, WIDTH bits unsigned: |a| and |b| when signed_mode=1, raw a and b otherwise.
- Capture the result sign: a[WIDTH-1]^b[WIDTH-1] when signed, 0 otherwise.
- Clear the internal 2*WIDTH accumulator.
- Load the multiplicand shift register with the zero-extended magnitude of a.
- Clear the bit counter.

Each CALC cycle:
- If the LSB of the multiplier register is 1, add the multiplicand shift register to the accumulator.
- Shift the multiplicand left by 1 and the multiplier right by 1.
- Increment the counter.
- After the WIDTH-th CALC cycle, go to DONE.

Arithmetic:
- All additions are 2*WIDTH bits wide with no carry-out.
- The magnitude of the most negative operand (e.g. -8 for WIDTH=4) is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
- The maximum product magnitude, 2^(2*WIDTH-2), fits, so no overflow is possible in either mode.

Result load and hold:
- On the CALC->DONE transition, product is loaded with the accumulator, negated (two's complement) if the captured sign is 1.
- A zero result stays 0 regardless of sign.
- product holds its value through IDLE and the next CALC. It changes only on the CALC->DONE edge or on reset.

Boundary conditions:
- start while busy (CALC or DONE) is ignored. It is not queued.
- start held high continuously produces back-to-back operations: accepted in each IDLE cycle, so one operation every WIDTH+2 cycles.
- Operand or signed_mode changes after acceptance have no effect on the operation in flight.
- Reset asserted mid-operation aborts it:
  - Returns to IDLE, clears product to 0.
  - No done pulse is generated.

## Timing
- Reset values: busy=0, done=0, product=0, state IDLE, internal registers 0.
- Reset release: the first edge with rst_n=1 may accept start.
- start sampled at edge t0:
  - busy=1 after t0.
  - CALC occupies edges t0+1 .. t0+WIDTH.
  - product is updated and done=1 after edge t0+WIDTH.
  - done=0 and busy=0 after edge t0+WIDTH+1.
- Latency from the accepting edge to the done edge is WIDTH cycles. Throughput is one result per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle: rst_n low mid-cycle -> busy=0, done=0, product=0 immediately (asynchronous); no output change with start=0.
- Unsigned, WIDTH=4:
  - a=15, b=15, signed_mode=0 -> done pulses after exactly 4 CALC cycles, product=8'd225.
  - a=0, b=9 -> product=0.
- Signed, WIDTH=4:
  - a=-3 (4'hD), b=5 -> product=8'hF1 (-15).
  - a=-8, b=-8 -> 8'h40 (64).
  - a=-8, b=7 -> 8'hC8 (-56).
- Handshake:
  - start re-pulsed during CALC with new operands -> ignored; the first result is unchanged and only one done pulse occurs.
  - start held high -> done pulses every 6 cycles.
- Abort: rst_n asserted at the 2nd CALC cycle -> no done, product=0; a fresh start=1 with a=2, b=3 after release -> product=6.
- Parameter sweep WIDTH=8: random signed and unsigned operands against a reference model. Check product matches, done occurs 8 cycles after acceptance, and product is stable between done pulses.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, signed or unsigned, start/done handshake.
// The product register holds its value between operations and only reloads on completion.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   acc_sum_s;

  // The most negative operand maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
    return ~v + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    acc_sum_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CALC;
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, magnitude(a, signed_mode & a[WIDTH-1])};
          mplier_d = magnitude(b, signed_mode & b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d    = acc_sum_s;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = ST_DONE;
          product_d = sign_q ? negate(acc_sum_s) : acc_sum_s;
        end else begin
          state_d   = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=4 and WIDTH=8: vector table, handshake corners,
// and a per-cycle scoreboard that predicts busy/done/product from a behavioural model.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int n_cmp  = 0;
  int n_fail = 0;

  int          m_cnt[2];
  logic [15:0] m_prod[2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [7:0] exp;
  } vec4_t;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .signed_mode(sm4),
    .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
    .busy(busy8), .done(done8), .product(product8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference product from integer arithmetic, truncated to 2*w bits
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] av, input logic [7:0] bv,
                                          input logic sm);
    int x;
    int y;
    int p;
    logic [31:0] pp;
    logic [31:0] mask;
    x = int'(av);
    y = int'(bv);
    if (sm && av[w-1]) x = x - (1 << w);
    if (sm && bv[w-1]) y = y - (1 << w);
    p = x * y;
    pp = 32'(p);
    mask = (32'd1 << (2 * w)) - 32'd1;
    pp = pp & mask;
    return pp[15:0];
  endfunction

  // One cycle of the behavioural model for DUT idx, then compare all outputs
  task automatic step(input int idx, input int w, input logic rs, input logic st,
                      input logic [7:0] av, input logic [7:0] bv, input logic sm,
                      input logic bz, input logic dn, input logic [15:0] pr);
    logic [15:0] e;
    if (!rs) begin
      m_cnt[idx] = 0;
      m_prod[idx] = 16'h0000;
      if (idx == 0) q0.delete(); else q1.delete();
    end else if (m_cnt[idx] == 0) begin
      if (st) begin
        e = ref_mul(w, av, bv, sm);
        if (idx == 0) q0.push_back(e); else q1.push_back(e);
        m_cnt[idx] = w + 1;
      end
    end else begin
      m_cnt[idx] = m_cnt[idx] - 1;
      if (m_cnt[idx] == 1) begin
        if (idx == 0) m_prod[idx] = q0.pop_front(); else m_prod[idx] = q1.pop_front();
      end
    end
    chk($sformatf("busy[w%0d]", w), {15'h0, bz}, {15'h0, (m_cnt[idx] > 0)});
    chk($sformatf("done[w%0d]", w), {15'h0, dn}, {15'h0, (m_cnt[idx] == 1)});
    chk($sformatf("product[w%0d]", w), pr, m_prod[idx]);
  endtask

  // Scoreboard monitor: samples inputs at the edge, checks outputs 1 time unit later
  initial begin
    logic s_rst, s_st4, s_sm4, s_st8, s_sm8;
    logic [3:0] s_a4, s_b4;
    logic [7:0] s_a8, s_b8;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_prod[0] = 16'h0000;
    m_prod[1] = 16'h0000;
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_st4 = start4; s_a4 = a4; s_b4 = b4; s_sm4 = sm4;
      s_st8 = start8; s_a8 = a8; s_b8 = b8; s_sm8 = sm8;
      #1;
      step(0, 4, s_rst, s_st4, {4'h0, s_a4}, {4'h0, s_b4}, s_sm4, busy4, done4, {8'h00, product4});
      step(1, 8, s_rst, s_st8, s_a8, s_b8, s_sm8, busy8, done8, product8);
    end
  end

  // Launch one operation on DUT idx, scramble the inputs afterwards, wait for done
  task automatic run_op(input int idx, input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                        input logic [15:0] texp, input string nm);
    bit seen;
    logic [15:0] act;
    @(negedge clk);
    if (idx == 0) begin start4 = 1'b1; a4 = ta[3:0]; b4 = tb[3:0]; sm4 = tsm; end
    else begin start8 = 1'b1; a8 = ta; b8 = tb; sm8 = tsm; end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    if (idx == 0) begin a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom); end
    else begin a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom); end
    seen = 1'b0;
    act = 16'h0000;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if ((idx == 0) ? done4 : done8) begin
        seen = 1'b1;
        act = (idx == 0) ? {8'h00, product4} : product8;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: done timeout, got no done expected done within 20 cycles", nm);
    end else begin
      chk(nm, act, texp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec4_t vt[10];
    int cnt;
    logic [7:0] ra, rb;
    logic rsm;

    vt[0] = '{a: 4'd15, b: 4'd15, sm: 1'b0, exp: 8'd225};
    vt[1] = '{a: 4'd0,  b: 4'd9,  sm: 1'b0, exp: 8'd0};
    vt[2] = '{a: 4'hD,  b: 4'd5,  sm: 1'b1, exp: 8'hF1};
    vt[3] = '{a: 4'h8,  b: 4'h8,  sm: 1'b1, exp: 8'h40};
    vt[4] = '{a: 4'h8,  b: 4'd7,  sm: 1'b1, exp: 8'hC8};
    vt[5] = '{a: 4'd7,  b: 4'd7,  sm: 1'b1, exp: 8'h31};
    vt[6] = '{a: 4'hF,  b: 4'hF,  sm: 1'b1, exp: 8'h01};
    vt[7] = '{a: 4'd0,  b: 4'h8,  sm: 1'b1, exp: 8'h00};
    vt[8] = '{a: 4'd9,  b: 4'd3,  sm: 1'b0, exp: 8'h1B};
    vt[9] = '{a: 4'hF,  b: 4'd1,  sm: 1'b0, exp: 8'h0F};

    rst_n = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; sm4 = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {15'h0, busy4}, 16'h0000);
    chk("reset_done", {15'h0, done4}, 16'h0000);
    chk("reset_product", {8'h00, product4}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_product", {8'h00, product4}, 16'h0000);

    for (int i = 0; i < 10; i++)
      run_op(0, {4'h0, vt[i].a}, {4'h0, vt[i].b}, vt[i].sm, {8'h00, vt[i].exp},
             $sformatf("vec4_%0d", i));

    // start re-pulsed during CALC must be ignored
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd7; sm4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    @(negedge clk);
    start4 = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) begin
        cnt++;
        chk("repulse_product", {8'h00, product4}, 16'd14);
      end
    end
    chk("repulse_done_count", 16'(cnt), 16'd1);

    // start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0;
    cnt = 0;
    repeat (18) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    start4 = 1'b0;
    chk("held_done_count", 16'(cnt), 16'd3);
    repeat (4) @(negedge clk);

    // asynchronous abort during the second CALC cycle
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd5; sm4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {15'h0, busy4}, 16'h0000);
    chk("abort_done", {15'h0, done4}, 16'h0000);
    chk("abort_product", {8'h00, product4}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'd2, 8'd3, 1'b0, 16'd6, "after_abort");

    // WIDTH=8 corners and random sweep
    run_op(1, 8'h80, 8'h80, 1'b1, 16'h4000, "w8_minmin");
    run_op(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_maxu");
    run_op(1, 8'h80, 8'h7F, 1'b1, 16'hC080, "w8_minmax");
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rsm = 1'($urandom);
      run_op(1, ra, rb, rsm, ref_mul(8, ra, rb, rsm), $sformatf("w8_rand_%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
